// File: rtl/freq_meter_gated.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a fixed window of
// GATE_CYCLES clock cycles and presents each result on a valid/ack interface.
module freq_meter_gated #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ack,
    output logic             overflow,
    output logic             overrun,
    output logic             busy,
    output logic             gate_led
);

    localparam int unsigned TMR_W = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               prev_q;
    logic               rise_c;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;

    // Metastability chain followed by a one-flop edge detector.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start || continuous) state_d = S_ARM;
            S_ARM:  state_d = S_GATE;
            S_GATE: if (timer_q == TMR_LAST) state_d = S_DONE;
            S_DONE: state_d = continuous ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and result-interface next values.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        timer_d    = timer_q;
        sat_d      = sat_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        busy_d     = (state_d != S_IDLE);
        led_d      = (state_d == S_GATE);
        case (state_q)
            S_ARM: begin
                edge_cnt_d = '0;
                timer_d    = '0;
                sat_d      = 1'b0;
            end
            S_GATE: begin
                timer_d = timer_q + TMR_W'(1);
                if (rise_c) begin
                    if (&edge_cnt_q) sat_d = 1'b1;
                    else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (state_q == S_DONE) begin
            count_d    = edge_cnt_q;
            overflow_d = sat_q;
            valid_d    = 1'b1;
            if (valid_q && !count_ack) overrun_d = 1'b1;
        end else if (count_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            edge_cnt_q <= '0;
            timer_q    <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            timer_q    <= timer_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            led_q      <= led_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign gate_led    = led_q;

endmodule

// File: tb/tb_freq_meter_gated.sv
// Bench for freq_meter_gated: a 32-bit and an 8-bit instance share stimulus; expected counts come
// from a log of input rising edges and the gate window implied by when start was issued.
module tb_freq_meter_gated;

    localparam int unsigned GC   = 1000;
    localparam int          MAXC = 40000;

    logic        clk = 1'b0;
    logic        rst_n, sig_in, start, continuous, count_ack;
    logic [31:0] count;
    logic        count_valid, overflow, overrun, busy, gate_led;
    logic [7:0]  count8;
    logic        valid8, ovf8, ovr8, busy8, led8;

    int   cyc = 0;
    bit   rise_at [MAXC];
    logic sig_last;
    int   checks = 0;
    int   failures = 0;

    freq_meter_gated #(.GATE_CYCLES(GC), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .count(count), .count_valid(count_valid),
        .count_ack(count_ack), .overflow(overflow), .overrun(overrun),
        .busy(busy), .gate_led(gate_led));

    freq_meter_gated #(.GATE_CYCLES(GC), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .count(count8), .count_valid(valid8),
        .count_ack(count_ack), .overflow(ovf8), .overrun(ovr8),
        .busy(busy8), .gate_led(led8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation ran past %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    // Rising edges driven in cycles k .. k+GC-1 fall inside the gate opened by a start driven in cycle k.
    function automatic int exp_rises(input int k);
        int n = 0;
        for (int i = k; i < k + int'(GC); i++) if (i >= 0 && i < MAXC && rise_at[i]) n++;
        return n;
    endfunction

    function automatic int sat8(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic gen(input int mode, input int r);
        case (mode)
            0:       return logic'(r % 2 != 0);
            1:       return logic'($urandom_range(0, 1));
            2:       return 1'b0;
            3:       return 1'b1;
            4:       return logic'($urandom_range(0, 7) == 0);
            default: return logic'(r == -1 || r == int'(GC) - 1);
        endcase
    endfunction

    task automatic drive(input logic s, input logic st, input logic cont, input logic ack);
        @(negedge clk);
        if (s && !sig_last && cyc < MAXC) rise_at[cyc] = 1'b1;
        sig_last   = s;
        sig_in     = s;
        start      = st;
        continuous = cont;
        count_ack  = ack;
    endtask

    task automatic run_gate(input int mode, input bit ack_done, input int restart_r,
                            output int k, output int led_n, output logic busy_arm,
                            output logic valid_pre);
        k = 0;
        led_n = 0;
        busy_arm = 1'b0;
        valid_pre = 1'b0;
        for (int r = -8; r <= int'(GC) + 3; r++) begin
            drive(gen(mode, r), logic'(r == 0 || r == restart_r), 1'b0,
                  logic'(ack_done && r == int'(GC) + 2));
            if (r == 0) k = cyc;
            if (gate_led) led_n++;
            if (r == 1) busy_arm = busy;
            if (r == int'(GC) + 2) valid_pre = count_valid;
        end
    endtask

    task automatic test_ack(input int e);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count_valid, overrun, valid8, ovr8} !== 4'b0) begin
            failures++;
            $display("FAIL ack_clear got valid=%b overrun=%b valid8=%b ovr8=%b expected all 0",
                     count_valid, overrun, valid8, ovr8);
        end
        checks++;
        if (count !== 32'(e)) begin
            failures++;
            $display("FAIL ack_count_kept got=%0d expected=%0d", count, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sig_in = 1'b0; start = 1'b0; continuous = 1'b0; count_ack = 1'b0;
        sig_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 32'd0 || count8 !== 8'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d/%0d expected=0", count, count8);
        end
        checks++;
        if ({count_valid, overflow, overrun, busy, gate_led} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=00000",
                     {count_valid, overflow, overrun, busy, gate_led});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b expected=0", busy);
        end
    endtask

    task automatic test_single_50mhz();
        int k, led_n, e;
        logic busy_arm, valid_pre;
        run_gate(0, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
        e = exp_rises(k);
        checks++;
        if (valid_pre !== 1'b0 || count_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_valid_timing got pre=%b post=%b expected 0 then 1",
                     valid_pre, count_valid);
        end
        checks++;
        if (busy_arm !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got arm=%b after=%b expected 1 then 0", busy_arm, busy);
        end
        checks++;
        if (led_n != int'(GC)) begin
            failures++;
            $display("FAIL single_gate_led got=%0d cycles expected=%0d", led_n, GC);
        end
        checks++;
        if (count !== 32'(e) || count !== 32'd500 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_count got=%0d ovf=%b expected=%0d (500) ovf=0", count, overflow, e);
        end
        checks++;
        if (count8 !== 8'(sat8(e)) || ovf8 !== 1'b1) begin
            failures++;
            $display("FAIL sat8_count got=%0d ovf=%b expected=%0d ovf=1", count8, ovf8, sat8(e));
        end
        test_ack(e);
    endtask

    task automatic test_random();
        int k, led_n, e;
        logic busy_arm, valid_pre;
        for (int m = 0; m < 2; m++) begin
            run_gate((m == 0) ? 1 : 4, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
            e = exp_rises(k);
            checks++;
            if (count !== 32'(e) || overflow !== 1'b0) begin
                failures++;
                $display("FAIL random_count mode=%0d got=%0d ovf=%b expected=%0d ovf=0",
                         m, count, overflow, e);
            end
            checks++;
            if (count8 !== 8'(sat8(e)) || ovf8 !== logic'(e > 255)) begin
                failures++;
                $display("FAIL random_count8 mode=%0d got=%0d ovf=%b expected=%0d ovf=%b",
                         m, count8, ovf8, sat8(e), e > 255);
            end
            test_ack(e);
        end
    endtask

    task automatic test_const();
        int k, led_n;
        logic busy_arm, valid_pre;
        for (int m = 2; m <= 3; m++) begin
            run_gate(m, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
            checks++;
            if (count !== 32'd0 || count8 !== 8'd0 || overflow !== 1'b0 || count_valid !== 1'b1) begin
                failures++;
                $display("FAIL const_level=%0d got=%0d/%0d ovf=%b valid=%b expected 0/0 ovf=0 valid=1",
                         m - 2, count, count8, overflow, count_valid);
            end
            test_ack(0);
        end
    endtask

    task automatic test_continuous();
        int k1, e1, e2;
        k1 = 0;
        e2 = 0;
        for (int r = -8; r <= 2 * int'(GC) + 5; r++) begin
            drive(gen(0, r), 1'b0, logic'(r >= 0 && r < int'(GC) + 502), 1'b0);
            if (r == 0) k1 = cyc;
            if (r == int'(GC) + 3) begin
                e1 = exp_rises(k1);
                checks++;
                if (count !== 32'(e1) || count_valid !== 1'b1 || overrun !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL cont_first got=%0d valid=%b ovr=%b busy=%b expected=%0d 1 0 1",
                             count, count_valid, overrun, busy, e1);
                end
            end
        end
        e2 = exp_rises(k1 + int'(GC) + 2);
        checks++;
        if (count !== 32'(e2) || count !== 32'd500 || count_valid !== 1'b1) begin
            failures++;
            $display("FAIL cont_second got=%0d valid=%b expected=%0d (500) valid=1",
                     count, count_valid, e2);
        end
        checks++;
        if (overrun !== 1'b1 || ovr8 !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_overrun got ovr=%b ovr8=%b busy=%b expected 1 1 0", overrun, ovr8, busy);
        end
        test_ack(e2);
    endtask

    task automatic test_start_ignored();
        int k, led_n;
        logic busy_arm, valid_pre;
        bit busy_seen;
        run_gate(5, 1'b0, 12, k, led_n, busy_arm, valid_pre);
        checks++;
        if (count !== 32'd1 || count !== 32'(exp_rises(k)) || count_valid !== 1'b1) begin
            failures++;
            $display("FAIL edge_window got=%0d valid=%b expected=1 valid=1", count, count_valid);
        end
        busy_seen = 1'b0;
        for (int i = 0; i < int'(GC) + 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen || count_valid !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored got busy_seen=%b valid=%b ovr=%b expected 0 1 0",
                     busy_seen, count_valid, overrun);
        end
        test_ack(1);
    endtask

    task automatic test_back_to_back();
        int k, led_n, e;
        logic busy_arm, valid_pre;
        run_gate(1, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
        checks++;
        if (overrun !== 1'b0 || count_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got ovr=%b valid=%b expected 0 1", overrun, count_valid);
        end
        run_gate(4, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
        e = exp_rises(k);
        checks++;
        if (count !== 32'(e) || count_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overwrite got=%0d valid=%b ovr=%b expected=%0d 1 1",
                     count, count_valid, overrun, e);
        end
        run_gate(1, 1'b1, -1000, k, led_n, busy_arm, valid_pre);
        e = exp_rises(k);
        checks++;
        if (count !== 32'(e) || count_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack_at_done got=%0d valid=%b ovr=%b expected=%0d 1 1",
                     count, count_valid, overrun, e);
        end
        test_ack(e);
    endtask

    task automatic test_reset_mid();
        int k, led_n, e;
        logic busy_arm, valid_pre;
        bit bad;
        for (int r = -8; r <= 402; r++) drive((r < 402) ? gen(0, r) : 1'b0, logic'(r == 0), 1'b0, 1'b0);
        checks++;
        if (gate_led !== 1'b1) begin
            failures++;
            $display("FAIL mid_gate_led got=%b expected=1", gate_led);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 32'd0 || count8 !== 8'd0 ||
            {count_valid, overflow, overrun, busy, gate_led} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset got count=%0d flags=%b expected 0 00000",
                     count, {count_valid, overflow, overrun, busy, gate_led});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (busy !== 1'b0 || count_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mid_reset_idle got busy/valid activity after release expected none");
        end
        run_gate(0, 1'b0, -1000, k, led_n, busy_arm, valid_pre);
        e = exp_rises(k);
        checks++;
        if (count !== 32'(e) || count !== 32'd500 || count_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_next got=%0d valid=%b expected=%0d (500) valid=1",
                     count, count_valid, e);
        end
        test_ack(e);
    endtask

    initial begin
        test_reset();
        test_single_50mhz();
        test_random();
        test_const();
        test_continuous();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
